// File: rtl/oflow_score_scheduler_pkg.sv
// Shared core definitions: datapath widths, scheduler state type, score init.
`ifndef SCORE_LEN
`define SCORE_LEN 32
`endif
`ifndef ID_LEN
`define ID_LEN 8
`endif
`ifndef DATA_TO_PE_WIDTH
`define DATA_TO_PE_WIDTH 64
`endif

package oflow_core_define;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    LAUNCH,
    WAIT,
    UPDATE,
    DONE
  } sched_state_t;

  // Worst possible score; any real metric result beats it.
  localparam logic [`SCORE_LEN-1:0] SCORE_INIT = '1;

endpackage

// File: rtl/oflow_score_scheduler_line_dbuf.sv
// Double-buffered feature line: shadow is filled by fetch or prefetch,
// active feeds the metric and only changes on swap.
module oflow_line_dbuf #(
  parameter int W = `DATA_TO_PE_WIDTH
) (
  input  logic         clk,
  input  logic         reset_N,
  input  logic [W-1:0] rd_data,
  input  logic         fetch_load,  // demand fetch: rd_data valid this cycle
  input  logic         pf_issue,    // prefetch read issued this cycle
  input  logic         swap,        // shadow -> active, clears prefetched
  output logic [W-1:0] active,
  output logic         prefetched
);

  logic [W-1:0] shadow;
  logic         pf_pend;

  // Prefetch data returns one cycle after the read; the active line is
  // never touched by it so the metric sees a stable input.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      shadow     <= '0;
      active     <= '0;
      pf_pend    <= 1'b0;
      prefetched <= 1'b0;
    end else begin
      pf_pend <= pf_issue;
      if (fetch_load || pf_pend) shadow <= rd_data;
      if (swap) begin
        active     <= shadow;
        prefetched <= 1'b0;
      end else if (pf_issue) begin
        prefetched <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/oflow_score_scheduler.sv
// Scans all previous-frame objects through one similarity metric and keeps
// the minimum score/id; prefetches the next line on the metric's hint.
module oflow_score_scheduler
  import oflow_core_define::*;
#(
  parameter int NUM_PREV    = 16,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic                         clk,
  input  logic                         reset_N,
  input  logic                         start,
  input  logic [ADDR_W:0]              num_prev,
  output logic                         rd_en,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic [`DATA_TO_PE_WIDTH-1:0] rd_data,
  output logic [`DATA_TO_PE_WIDTH-1:0] features_of_prev,
  output logic                         sm_start,
  input  logic                         sm_valid,
  input  logic                         sm_read_new_line,
  input  logic [`SCORE_LEN-1:0]        sm_score,
  input  logic [`ID_LEN-1:0]           sm_id,
  output logic                         busy,
  output logic                         done,
  output logic [`SCORE_LEN-1:0]        best_score,
  output logic [`ID_LEN-1:0]           best_id,
  output logic                         no_match,
  output logic                         timeout_err
);

  sched_state_t          state, nxt;
  logic [ADDR_W:0]       idx, idx_nx, n_lat;
  logic [TO_W-1:0]       to_cnt;
  logic [`SCORE_LEN-1:0] score_q;
  logic [`ID_LEN-1:0]    id_q;
  logic                  prefetched, pf_issue, pf_ok, to_hit;

  assign idx_nx = idx + 1'b1;
  assign pf_ok  = idx_nx < n_lat;
  // The counter clears in LAUNCH, so abort is decided TIMEOUT_CYC-1 cycles
  // after sm_start and DONE lands exactly TIMEOUT_CYC cycles after it.
  assign to_hit = to_cnt == TO_W'(TIMEOUT_CYC - 2);
  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = state == DONE;

  oflow_line_dbuf #(.W(`DATA_TO_PE_WIDTH)) u_dbuf (
    .clk        (clk),
    .reset_N    (reset_N),
    .rd_data    (rd_data),
    .fetch_load (state == LOAD),
    .pf_issue   (pf_issue),
    .swap       (state == LAUNCH),
    .active     (features_of_prev),
    .prefetched (prefetched)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state <= IDLE;
    else          state <= nxt;
  end

  // Next state plus read/launch strobes.
  always_comb begin
    nxt      = state;
    rd_en    = 1'b0;
    rd_addr  = idx[ADDR_W-1:0];
    sm_start = 1'b0;
    pf_issue = 1'b0;
    case (state)
      IDLE:   if (start) nxt = (num_prev == '0) ? DONE : FETCH;
      FETCH: begin
        rd_en = 1'b1;
        nxt   = LOAD;
      end
      LOAD:   nxt = LAUNCH;
      LAUNCH: begin
        sm_start = 1'b1;
        nxt      = WAIT;
      end
      WAIT: begin
        // A hint coinciding with valid still prefetches.
        if (sm_read_new_line && pf_ok) begin
          rd_en    = 1'b1;
          rd_addr  = idx_nx[ADDR_W-1:0];
          pf_issue = 1'b1;
        end
        if (sm_valid)    nxt = UPDATE;
        else if (to_hit) nxt = DONE;
      end
      UPDATE: begin
        if (idx_nx == n_lat) nxt = DONE;
        else if (prefetched) nxt = LAUNCH;
        else                 nxt = FETCH;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Scan bookkeeping, timeout counter and best-score tracking.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      idx         <= '0;
      n_lat       <= '0;
      to_cnt      <= '0;
      score_q     <= '0;
      id_q        <= '0;
      best_score  <= SCORE_INIT;
      best_id     <= '0;
      no_match    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_lat       <= num_prev;
          idx         <= '0;
          best_score  <= SCORE_INIT;
          best_id     <= '0;
          timeout_err <= 1'b0;
          no_match    <= num_prev == '0;
        end
        LAUNCH: to_cnt <= '0;
        WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (sm_valid) begin
            score_q <= sm_score;
            id_q    <= sm_id;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
          end
        end
        UPDATE: begin
          // Strict compare: on a tie the earlier line wins.
          if (score_q < best_score) begin
            best_score <= score_q;
            best_id    <= id_q;
          end
          idx <= idx_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oflow_score_scheduler.sv
// Directed bench: history-buffer and metric models driven per cycle, with a
// scoreboard that derives best score/id and timing from the scan table.
`ifndef SCORE_LEN
`define SCORE_LEN 32
`endif
`ifndef ID_LEN
`define ID_LEN 8
`endif
`ifndef DATA_TO_PE_WIDTH
`define DATA_TO_PE_WIDTH 64
`endif

module tb_oflow_score_scheduler;
  localparam int NP = 16, AW = 4, TO = 64, TW = 7;
  localparam int DW = `DATA_TO_PE_WIDTH, SW = `SCORE_LEN, IW = `ID_LEN;

  logic          clk = 1'b0, reset_N = 1'b0, start = 1'b0;
  logic [AW:0]   num_prev = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0, features_of_prev;
  logic          sm_start, sm_valid = 1'b0, sm_read_new_line = 1'b0;
  logic [SW-1:0] sm_score = '0, best_score;
  logic [IW-1:0] sm_id = '0, best_id;
  logic          busy, done, no_match, timeout_err;

  always #5 clk = ~clk;

  oflow_score_scheduler #(.NUM_PREV(NP), .ADDR_W(AW), .TIMEOUT_CYC(TO), .TO_W(TW)) dut (
    .clk(clk), .reset_N(reset_N), .start(start), .num_prev(num_prev),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .features_of_prev(features_of_prev), .sm_start(sm_start),
    .sm_valid(sm_valid), .sm_read_new_line(sm_read_new_line),
    .sm_score(sm_score), .sm_id(sm_id), .busy(busy), .done(done),
    .best_score(best_score), .best_id(best_id), .no_match(no_match),
    .timeout_err(timeout_err)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] mem [NP];
  logic [SW-1:0] sc  [NP];
  logic [IW-1:0] idt [NP];
  int cur_num, lat, hint_off, never;
  logic nxt_start = 1'b0;
  logic [AW:0] nxt_num = '0;
  logic rd_pend = 1'b0;
  logic [AW-1:0] rd_pend_addr = '0;
  logic m_active = 1'b0, live = 1'b0;
  int m_cnt, n_start, n_done, n_rd, start_cyc, done_cyc, valid_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs at the falling edge, then observe and score.
  task automatic step();
    int line;
    @(negedge clk);
    start     = nxt_start;
    num_prev  = nxt_num;
    nxt_start = 1'b0;
    rd_data   = rd_pend ? mem[rd_pend_addr] : {(DW/16){16'hBAD0}};
    sm_valid = 1'b0; sm_read_new_line = 1'b0; sm_score = '0; sm_id = '0;
    if (m_active) begin
      m_cnt++;
      if (hint_off >= 0 && m_cnt == lat - hint_off) sm_read_new_line = 1'b1;
      if (never == 0 && m_cnt == lat) begin
        line = int'(features_of_prev[AW-1:0]);
        sm_valid = 1'b1; sm_score = sc[line]; sm_id = idt[line];
        m_active = 1'b0; valid_cyc = cyc;
        chk("active_line", features_of_prev, mem[n_start-1]);
      end
    end
    #1;
    if (rd_en) begin
      n_rd++;
      chk("rd_addr", 64'(rd_addr), 64'(n_start));
    end
    if (sm_read_new_line) chk("prefetch_rd_en", rd_en, n_start < cur_num);
    rd_pend = rd_en; rd_pend_addr = rd_addr;
    if (sm_start) begin
      if (n_start > 0) chk("launch_gap", 64'(cyc - valid_cyc), (hint_off >= 0) ? 2 : 4);
      n_start++; m_active = 1'b1; m_cnt = 0;
    end
    chk("busy", busy, live && !done);
    if (done) begin
      n_done++; done_cyc = cyc; live = 1'b0; m_active = 1'b0;
    end
    if (start && !live && !done) begin
      start_cyc = cyc;
      if (num_prev != '0) live = 1'b1;
    end
    cyc++;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_sm_start", sm_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_best_score", best_score, {SW{1'b1}});
    chk("rst_best_id", best_id, 0);
    chk("rst_no_match", no_match, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_features", features_of_prev, 0);
  endtask

  task automatic run_scan(input int num, input int l, input int h, input int nv, input int poke);
    int budget;
    logic [SW-1:0] exp_s;
    logic [IW-1:0] exp_i;
    cur_num = num; lat = l; hint_off = h; never = nv;
    n_start = 0; n_done = 0; n_rd = 0;
    nxt_num = (AW+1)'(num); nxt_start = 1'b1;
    step();
    budget = 0;
    while (n_done == 0 && budget < 400) begin
      step(); budget++;
      if (poke == 1 && n_start == 1) begin
        poke = 0; nxt_start = 1'b1; nxt_num = '0;   // start while busy
      end
    end
    chk("done_seen", n_done, 1);
    step();
    chk("done_one_cycle", n_done, 1);
    exp_s = '1; exp_i = '0;
    if (nv == 0)
      for (int i = 0; i < num; i++)
        if (sc[i] < exp_s) begin exp_s = sc[i]; exp_i = idt[i]; end
    chk("best_score", best_score, exp_s);
    chk("best_id", best_id, exp_i);
    chk("no_match", no_match, num == 0);
    chk("timeout_err", timeout_err, nv != 0 && num > 0);
    chk("sm_starts", n_start, (num == 0) ? 0 : (nv != 0) ? 1 : num);
  endtask

  initial begin
    int b;
    for (int i = 0; i < NP; i++) begin
      mem[i] = 64'hC0DE_5EED_0000_0000 | 64'(i);
      sc[i] = '0; idt[i] = '0;
    end
    repeat (2) @(negedge clk);
    #1 chk_reset_vals();
    @(negedge clk); reset_N = 1'b1;
    repeat (2) step();

    // Empty history: immediate done, no reads.
    run_scan(0, 4, -1, 0, 0);
    chk("nomatch_latency", 64'(done_cyc - start_cyc), 1);
    chk("nomatch_reads", n_rd, 0);

    // Three lines, no prefetch, with a start pulse while busy.
    sc[0] = 'h200; sc[1] = 'h080; sc[2] = 'h100;
    idt[0] = 5;    idt[1] = 9;    idt[2] = 2;
    run_scan(3, 4, -1, 0, 1);
    chk("lit_best_score_3", best_score, 'h80);
    chk("lit_best_id_3", best_id, 9);

    // Tie on equal scores, prefetch requested two cycles before valid.
    sc[0] = 'h40; sc[1] = 'h40; idt[0] = 7; idt[1] = 8;
    run_scan(2, 3, 2, 0, 0);
    chk("lit_tie_id", best_id, 7);

    // Prefetch request coincident with valid; minimum on the last line.
    sc[0] = 'h90; sc[1] = 'h30; sc[2] = 'h60; sc[3] = 'h10;
    idt[0] = 1;   idt[1] = 2;   idt[2] = 3;   idt[3] = 4;
    run_scan(4, 4, 0, 0, 0);
    chk("lit_last_min", best_id, 4);

    // Metric never answers.
    run_scan(2, 5, 2, 1, 0);
    chk("timeout_latency", 64'(done_cyc - start_cyc), TO + 3);
    chk("lit_timeout_flag", timeout_err, 1);

    // Reset while waiting on line 1.
    cur_num = 3; lat = 8; hint_off = -1; never = 0;
    n_start = 0; n_done = 0; nxt_num = 3; nxt_start = 1'b1;
    step();
    b = 0;
    while (n_start < 2 && b < 100) begin step(); b++; end
    chk("reached_line1", n_start, 2);
    repeat (3) step();
    @(negedge clk); reset_N = 1'b0;
    #1 chk_reset_vals();
    chk("no_done_on_reset", n_done, 0);
    m_active = 1'b0; live = 1'b0; rd_pend = 1'b0; n_start = 0;
    @(negedge clk); reset_N = 1'b1;
    step();

    // Full history depth with prefetch; tie between lines 1 and 9.
    for (int i = 0; i < NP; i++) begin
      sc[i]  = SW'(((i * 5 + 3) % 8) * 16 + 32);
      idt[i] = IW'(i + 100);
    end
    run_scan(NP, 5, 2, 0, 0);
    chk("lit_full_id", best_id, 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oflow_score_scheduler.md
Name: oflow_score_scheduler

Overview:
- Sequences one oflow_similarity_metric instance over all previous-frame objects for one current-frame object.
- Fetches previous-object feature lines from the history buffer, holding one active line and one prefetched line (double buffer).
- Pulses the metric start, collects each score/id, and keeps the best (minimum) score.
- Sits between the core control FSM and the PE datapath; reports best match and completion to the core.

Parameters:
- NUM_PREV, 16, maximum previous objects per frame (history buffer depth).
- ADDR_W, 4, history buffer address width, equal to clog2(NUM_PREV).
- TIMEOUT_CYC, 64, maximum cycles waiting for metric valid before abort.
- TO_W, 7, timeout counter width, large enough to hold TIMEOUT_CYC.

Ports:
- clk  in  1  clock.
- reset_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a scan; ignored while busy=1.
- num_prev  in  ADDR_W+1  count of valid previous objects, 0..NUM_PREV; sampled on start.
- rd_en  out  1  history buffer read strobe.
- rd_addr  out  ADDR_W  history buffer read address.
- rd_data  in  `DATA_TO_PE_WIDTH  feature line; valid exactly 1 cycle after rd_en.
- features_of_prev  out  `DATA_TO_PE_WIDTH  active line to the metric; stable from sm_start until sm_valid.
- sm_start  out  1  metric start pulse.
- sm_valid  in  1  metric score valid.
- sm_read_new_line  in  1  metric prefetch hint, asserted 2 cycles before sm_valid.
- sm_score  in  `SCORE_LEN  metric score, q26.6.
- sm_id  in  `ID_LEN  id of the active line.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan end.
- best_score  out  `SCORE_LEN  minimum score of the scan.
- best_id  out  `ID_LEN  id of the minimum-score line.
- no_match  out  1  set when num_prev was 0.
- timeout_err  out  1  set when the scan was aborted by timeout.

Behaviour:
- Reset values: all outputs 0, except best_score = all ones; state IDLE; both line registers 0.
- States: IDLE, FETCH, LOAD, LAUNCH, WAIT, UPDATE, DONE.
- IDLE:
  - On start with num_prev==0: go to DONE; no_match=1; best_score all ones; best_id 0.
  - On start with num_prev>0: latch num_prev; clear rd index, best_score (all ones), no_match, timeout_err; go to FETCH.
- FETCH: rd_en=1, rd_addr=idx; go to LOAD.
- LOAD: capture rd_data into the shadow register; go to LAUNCH.
- LAUNCH:
  - Copy shadow into active register (drives features_of_prev); sm_start=1 for one cycle.
  - Clear timeout counter and the prefetched flag; go to WAIT.
- WAIT:
  - sm_read_new_line=1 and idx+1<num_prev: rd_en=1, rd_addr=idx+1; write rd_data to shadow the next cycle; set prefetched.
  - Prefetch never modifies the active register.
  - On sm_valid: register sm_score and sm_id; go to UPDATE.
  - If the counter reaches TIMEOUT_CYC with no sm_valid: timeout_err=1; go to DONE.
- UPDATE:
  - If sm_score < best_score (unsigned), update best_score and best_id. On a tie, keep the earlier (lower-index) line.
  - idx++. If idx==num_prev go to DONE; else if prefetched go to LAUNCH; else go to FETCH (no hint was seen).
- DONE: done=1 for one cycle; busy=0; go to IDLE. best_*, no_match and timeout_err hold until the next start.
- Busy: busy=1 in every state except IDLE and DONE.
- Throughput with prefetch: each line after the first costs metric latency + 2 cycles (UPDATE, LAUNCH).
- Simultaneous sm_read_new_line and sm_valid: the valid is accepted and the prefetch is still issued.
- start while busy: ignored.
- Reset mid-scan: immediate return to reset values; no done pulse.
- sm_valid outside WAIT: ignored.

Decomposition:
- Shared package (oflow_core_define): state enum type, and SCORE_INIT = all ones.
- Reuse existing `SCORE_LEN, `ID_LEN and `DATA_TO_PE_WIDTH from oflow_core_define.
- One natural sub-module: oflow_line_dbuf, holding the shadow/active line registers, load and swap controls, and the prefetched flag.

Test Plan:
- num_prev=0, start -> done pulse 1 cycle later; no_match=1; best_score=all ones; best_id=0; no rd_en.
- num_prev=3, scores 0x200/0x080/0x100, ids 5/9/2 -> best_score=0x080, best_id=9, done once, 3 sm_start pulses.
- num_prev=2, equal scores 0x40, ids 7/8 -> best_id=7.
- Metric model emits sm_read_new_line 2 cycles before sm_valid -> rd_addr=1 issued in WAIT; features_of_prev unchanged until LAUNCH; second sm_start 2 cycles after first sm_valid.
- Metric model never asserts sm_valid -> timeout_err=1 and done at start + TIMEOUT_CYC + 3 cycles.
- reset_N low during WAIT of line 1 -> all outputs at reset values; a new start scans from addr 0.
